// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  // Image header: little-endian 16-bit word count.
  localparam int unsigned HDR_BYTES  = 2;
  // Bytes per instruction word.
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte 0 lands in bits [7:0].
module instr_loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift;
  logic [1:0]  idx;

  // The fourth byte completes the word combinationally so the loader can
  // register it on the same edge the byte is accepted.
  always_comb begin
    word       = {byte_in, shift};
    word_valid = byte_valid && (idx == 2'(WORD_BYTES - 1));
  end

  // Shift earlier bytes down; the index wraps to 0 after the last byte.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift <= '0;
      idx   <= '0;
    end else if (byte_valid) begin
      shift <= {byte_in, shift[23:8]};
      idx   <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed program image from a byte stream into
// instruction memory, stalling the CPU while the load is in progress.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     mem_w_en,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              words_written
);

  // 17 bits so a depth of 2**16 still compares correctly against a 16-bit N.
  localparam logic [16:0] DEPTH = 17'(1) << RAM_ADDR_BITS;

  state_t                   state;
  logic [7:0]               len_lo;
  logic [15:0]              len;
  logic [RAM_ADDR_BITS-1:0] addr;
  logic                     arm;
  logic                     xfer;
  logic [15:0]              n_full;
  logic [31:0]              word;
  logic                     word_valid;

  // Handshake, rearm qualification and the header value being completed.
  always_comb begin
    xfer   = in_valid && in_ready;
    arm    = start && (state == IDLE || state == DONE || state == ERR);
    n_full = {in_data, len_lo};
  end

  instr_loader_byte_packer packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (arm),
    .byte_valid (xfer && (state == DATA)),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Loader FSM; every output is set for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len_lo        <= '0;
      len           <= '0;
      addr          <= '0;
      in_ready      <= 1'b0;
      mem_w_en      <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= LEN_LO;
            in_ready      <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len <= n_full;
            if (n_full == 16'd0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if ({1'b0, n_full} > DEPTH) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
              addr  <= '0;
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            state    <= WRITE;
            in_ready <= 1'b0;
            mem_w_en <= 1'b1;
            mem_addr <= addr;
            mem_data <= RAM_WIDTH'(word);
          end
        end
        WRITE: begin
          mem_w_en      <= 1'b0;
          words_written <= words_written + 16'd1;
          addr          <= addr + 1'b1;
          if (words_written + 16'd1 == len) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          mem_w_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
